// File: rtl/z80_af_regfile.sv
// z80_af_regfile: writeback stage after the 8-bit ALU adder.
// Holds the accumulator A and flag register F (Z80 layout {S,Z,Y,H,X,PV,N,C}),
// the shadow pair A'/F' for EX AF,AF', and handles POP AF loads.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   alu_valid/alu_ready ALU writeback handshake (accepted when both high)
//   alu_result, alu_*   adder result and flags
//   a_we                write alu_result into A on an accepted writeback
//   f_mask              per-bit F write enable for ALU writeback
//   ex_af               swap A/F with A'/F'
//   pop_valid, pop_data POP AF load of {A,F}
//   a_q, f_q, carry_q   current A, F and F[0]
//   busy                high the cycle after a swap or pop
//
// Optional feature: define Z80_UNDOC_XY_FLAGS_EN to copy alu_result[5]/[3]
// into the undocumented Y/X flags on ALU writeback; otherwise they are written 0.

module z80_af_regfile #(
    parameter logic [7:0] RESET_VAL = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [7:0]  alu_result,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_s,
    input  logic        alu_pv,
    input  logic        alu_h,
    input  logic        alu_n,
    input  logic        a_we,
    input  logic [7:0]  f_mask,
    input  logic        ex_af,
    input  logic        pop_valid,
    input  logic [15:0] pop_data,
    output logic [7:0]  a_q,
    output logic [7:0]  f_q,
    output logic        carry_q,
    output logic        busy
);

    logic [7:0] a_d, f_d;
    logic [7:0] a_sh_q, a_sh_d;
    logic [7:0] f_sh_q, f_sh_d;
    logic       busy_q, busy_d;
    // Low during reset; set on the first edge after release so alu_ready stays
    // low until then.
    logic       live_q;

    logic       flag_y, flag_x;
    logic [7:0] new_flags;
    logic       wb_en;

`ifdef Z80_UNDOC_XY_FLAGS_EN
    assign flag_y = alu_result[5];
    assign flag_x = alu_result[3];
`else
    assign flag_y = 1'b0;
    assign flag_x = 1'b0;
`endif

    assign new_flags = {alu_s, alu_z, flag_y, alu_h, flag_x, alu_pv, alu_n, alu_c};
    assign alu_ready = live_q && !pop_valid && !ex_af && !busy_q;
    assign wb_en     = alu_valid && alu_ready;
    assign carry_q   = f_q[0];
    assign busy      = busy_q;

    always_comb begin
        a_d    = a_q;
        f_d    = f_q;
        a_sh_d = a_sh_q;
        f_sh_d = f_sh_q;
        busy_d = 1'b0;
        if (pop_valid) begin
            a_d    = pop_data[15:8];
            f_d    = pop_data[7:0];
            busy_d = 1'b1;
        end else if (ex_af) begin
            a_d    = a_sh_q;
            f_d    = f_sh_q;
            a_sh_d = a_q;
            f_sh_d = f_q;
            busy_d = 1'b1;
        end else if (wb_en) begin
            if (a_we) begin
                a_d = alu_result;
            end
            // Masked bits keep their previous value.
            f_d = (f_q & ~f_mask) | (new_flags & f_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= RESET_VAL;
            f_q    <= RESET_VAL;
            a_sh_q <= RESET_VAL;
            f_sh_q <= RESET_VAL;
            busy_q <= 1'b0;
            live_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            f_q    <= f_d;
            a_sh_q <= a_sh_d;
            f_sh_q <= f_sh_d;
            busy_q <= busy_d;
            live_q <= 1'b1;
        end
    end

endmodule
